logic_reduce_acc: RTL and testbench

//  Parametrised successor to the 2-input gate cell: multi-beat, mode-selectable logic

---
 rtl/logic_reduce_pkg.sv | 26 ++
 rtl/logic_reduce_op.sv | 30 +++
 rtl/logic_reduce_acc.sv | 151 +++++++++++++++
 tb/tb_logic_reduce_acc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// logic_reduce_pkg
//   Shared types and helpers for the logic_reduce_acc block.
//   mode_e   : fold operation selected by in_mode on the first beat of a packet
//   state_e  : controller states of the accumulator FSM
//   identity : fill bit that makes the first-beat fold return the beat unchanged
package logic_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  // All-ones for AND/NAND, zero for OR/XOR; callers replicate it to any width.
  function automatic logic identity(input mode_e mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

endpackage

// File: rtl/logic_reduce_op.sv
// logic_reduce_op
//   Combinational bitwise fold of two WIDTH-bit vectors.
//   Ports:
//     i_a    in  WIDTH  running accumulator (or identity fill on a first beat)
//     i_b    in  WIDTH  incoming beat
//     i_mode in  mode_e operation
//     o_y    out WIDTH  folded vector
//   NAND folds as AND; the inversion is applied only at the output of the top,
//   so the accumulator always holds the plain AND of all beats.
module logic_reduce_op
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_a & i_b;
    case (i_mode)
      MODE_OR:  o_y = i_a | i_b;
      MODE_XOR: o_y = i_a ^ i_b;
      default:  o_y = i_a & i_b;
    endcase
  end

endmodule

// File: rtl/logic_reduce_acc.sv
// logic_reduce_acc
//   Multi-beat logic reduction unit. Folds a packet of WIDTH-bit beats with
//   AND/OR/XOR/NAND and presents the vector result, a single reduced bit and
//   the (saturating) beat count behind a valid/ready handshake.
//   Optional feature macro: LOGIC_REDUCE_OVF_EN adds the o_out_ovf flag.
//   Ports:
//     i_clk        in   1      clock, rising edge
//     i_rst        in   1      synchronous active-high reset
//     i_in_valid   in   1      beat present
//     o_in_ready   out  1      beat can be accepted (IDLE/ACCUM)
//     i_in_data    in   WIDTH  beat operand
//     i_in_last    in   1      final beat of packet
//     i_in_mode    in   2      fold op, sampled on first beat only
//     o_out_valid  out  1      result present (DONE)
//     i_out_ready  in   1      consumer takes result
//     o_out_vec    out  WIDTH  folded vector (inverted for NAND)
//     o_out_bit    out  1      reduction of accumulator across its bits
//     o_out_beats  out  CW     accepted beats, saturating at MAX_BEATS
//     o_out_ovf    out  1      packet exceeded MAX_BEATS (LOGIC_REDUCE_OVF_EN only)
//
//   state | meaning
//   IDLE  | waiting for first beat of a packet
//   ACCUM | folding further beats until in_last
//   DONE  | result held, waiting for out handshake
module logic_reduce_acc
  import logic_reduce_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  input  logic [1:0]       i_in_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_vec,
  output logic             o_out_bit,
  output logic [CW-1:0]    o_out_beats
`ifdef LOGIC_REDUCE_OVF_EN
  ,
  output logic             o_out_ovf
`endif
);

  localparam logic [CW-1:0] C_MAX = CW'(MAX_BEATS);

  state_e           r_state;
  state_e           w_next;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_beats;

  logic             w_accept;
  logic             w_result;
  logic             w_first;
  mode_e            w_fold_mode;
  logic [WIDTH-1:0] w_fold_a;
  logic [WIDTH-1:0] w_fold;

  assign o_in_ready  = (r_state != DONE);
  assign o_out_valid = (r_state == DONE);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_result    = o_out_valid & i_out_ready;
  assign w_first     = (r_state == IDLE);

  // First beat folds against the identity of the incoming mode, so the
  // same op instance serves both the first-beat and later-beat paths.
  assign w_fold_mode = w_first ? mode_e'(i_in_mode) : r_mode;
  assign w_fold_a    = w_first ? {WIDTH{identity(w_fold_mode)}} : r_acc;

  logic_reduce_op #(.WIDTH(WIDTH)) u_op (
    .i_a    (w_fold_a),
    .i_b    (i_in_data),
    .i_mode (w_fold_mode),
    .o_y    (w_fold)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = i_in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        if (w_accept && i_in_last) w_next = DONE;
      end
      DONE: begin
        if (w_result) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_mode  <= MODE_AND;
      r_beats <= '0;
    end else if (w_accept) begin
      r_acc <= w_fold;
      if (w_first) begin
        r_mode  <= w_fold_mode;
        r_beats <= CW'(1);
      end else if (r_beats != C_MAX) begin
        r_beats <= r_beats + CW'(1);
      end
    end
  end

`ifdef LOGIC_REDUCE_OVF_EN
  logic r_ovf;

  // Accept and result handshakes are mutually exclusive (in_ready is low in DONE).
  always_ff @(posedge i_clk) begin
    if (i_rst || w_result) r_ovf <= 1'b0;
    else if (w_accept && !w_first && (r_beats == C_MAX)) r_ovf <= 1'b1;
  end

  assign o_out_ovf = r_ovf;
`endif

  always_comb begin
    o_out_vec = r_acc;
    o_out_bit = &r_acc;
    case (r_mode)
      MODE_OR:   o_out_bit = |r_acc;
      MODE_XOR:  o_out_bit = ^r_acc;
      MODE_NAND: begin
        o_out_vec = ~r_acc;
        o_out_bit = ~&r_acc;
      end
      default: begin
        o_out_vec = r_acc;
        o_out_bit = &r_acc;
      end
    endcase
  end

  assign o_out_beats = r_beats;

endmodule

// File: tb/tb_logic_reduce_acc.sv
module tb_logic_reduce_acc;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_in_data;
  logic          i_in_last;
  logic [1:0]    i_in_mode;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [W-1:0]  o_out_vec;
  logic          o_out_bit;
  logic [CW-1:0] o_out_beats;
`ifdef LOGIC_REDUCE_OVF_EN
  logic          o_out_ovf;
`endif

  always #5 clk = ~clk;

  logic_reduce_acc #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_last   (i_in_last),
    .i_in_mode   (i_in_mode),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_vec   (o_out_vec),
    .o_out_bit   (o_out_bit),
    .o_out_beats (o_out_beats)
`ifdef LOGIC_REDUCE_OVF_EN
    ,
    .o_out_ovf   (o_out_ovf)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [1:0]      mode;
    logic [1:0]      mid;
    int              n;
    logic [7:0][7:0] d;
    logic [7:0]      ev;
    logic            eb;
    logic [2:0]      ebeats;
    logic            eovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: fold by the first beat's mode over all beats, then map outputs.
  task automatic model(input logic [1:0] mode, input int n, input logic [7:0][7:0] d,
                       output logic [7:0] ev, output logic eb, output logic [2:0] ebeats,
                       output logic eovf);
    logic [7:0] acc;
    acc = (mode == 2'b00 || mode == 2'b11) ? 8'hFF : 8'h00;
    for (int i = 0; i < n; i++) begin
      case (mode)
        2'b01:   acc = acc | d[i];
        2'b10:   acc = acc ^ d[i];
        default: acc = acc & d[i];
      endcase
    end
    case (mode)
      2'b00: begin ev = acc;  eb = &acc;  end
      2'b01: begin ev = acc;  eb = |acc;  end
      2'b10: begin ev = acc;  eb = ^acc;  end
      default: begin ev = ~acc; eb = ~&acc; end
    endcase
    ebeats = (n > MB) ? 3'(MB) : 3'(n);
    eovf   = (n > MB);
  endtask

  task automatic send_packet(input logic [1:0] mode, input logic [1:0] mid, input int n,
                             input logic [7:0][7:0] d, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_in_valid = 1'b0;
        i_in_data  = 8'($urandom);
        @(negedge clk);
      end
      i_in_valid = 1'b1;
      i_in_data  = d[i];
      i_in_mode  = (i == 0) ? mode : mid;
      i_in_last  = (i == n - 1);
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] ev, input logic eb,
                              input logic [2:0] ebeats, input logic eovf, input int stall,
                              input bit poke);
    chk({name, "/valid"}, 32'(o_out_valid), 32'd1);
    chk({name, "/vec"},   32'(o_out_vec),   32'(ev));
    chk({name, "/bit"},   32'(o_out_bit),   32'(eb));
    chk({name, "/beats"}, 32'(o_out_beats), 32'(ebeats));
    chk({name, "/in_ready_done"}, 32'(o_in_ready), 32'd0);
`ifdef LOGIC_REDUCE_OVF_EN
    chk({name, "/ovf"}, 32'(o_out_ovf), 32'(eovf));
`endif
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        i_in_valid = 1'b1;
        i_in_data  = 8'h00;
        i_in_mode  = 2'b00;
        i_in_last  = 1'b1;
      end
      @(negedge clk);
      chk({name, "/stall_valid"}, 32'(o_out_valid), 32'd1);
      chk({name, "/stall_vec"},   32'(o_out_vec),   32'(ev));
      chk({name, "/stall_beats"}, 32'(o_out_beats), 32'(ebeats));
      chk({name, "/stall_ready"}, 32'(o_in_ready),  32'd0);
    end
    i_in_valid  = 1'b0;
    i_in_last   = 1'b0;
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    chk({name, "/valid_after"}, 32'(o_out_valid), 32'd0);
    chk({name, "/ready_after"}, 32'(o_in_ready),  32'd1);
`ifdef LOGIC_REDUCE_OVF_EN
    chk({name, "/ovf_after"}, 32'(o_out_ovf), 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "/valid"}, 32'(o_out_valid), 32'd0);
    chk({name, "/ready"}, 32'(o_in_ready),  32'd1);
    chk({name, "/vec"},   32'(o_out_vec),   32'd0);
    chk({name, "/bit"},   32'(o_out_bit),   32'd0);
    chk({name, "/beats"}, 32'(o_out_beats), 32'd0);
`ifdef LOGIC_REDUCE_OVF_EN
    chk({name, "/ovf"}, 32'(o_out_ovf), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0]      ev;
    logic            eb;
    logic [2:0]      ebeats;
    logic            eovf;
    logic [7:0][7:0] d;
    logic [1:0]      mode;
    logic [1:0]      mid;
    int              n;

    // mode, mid-packet in_mode, beats, data (beat 0 in low byte), vec, bit, beats, ovf
    tbl[0] = '{2'b00, 2'b00, 1, {56'h0, 8'hFF},                8'hFF, 1'b1, 3'd1, 1'b0};
    tbl[1] = '{2'b10, 2'b01, 3, {40'h0, 8'h01, 8'hF0, 8'h0F},  8'hFE, 1'b1, 3'd3, 1'b0};
    tbl[2] = '{2'b11, 2'b11, 2, {48'h0, 8'h3F, 8'hF3},         8'hCC, 1'b1, 3'd2, 1'b0};
    tbl[3] = '{2'b01, 2'b01, 6, {16'h0, 48'h010101010101},     8'h01, 1'b1, 3'd4, 1'b1};
    tbl[4] = '{2'b00, 2'b10, 2, {48'h0, 8'h0F, 8'hF0},         8'h00, 1'b0, 3'd2, 1'b0};
    tbl[5] = '{2'b10, 2'b00, 2, {48'h0, 8'hAA, 8'hAA},         8'h00, 1'b0, 3'd2, 1'b0};
    tbl[6] = '{2'b11, 2'b01, 1, {56'h0, 8'hFF},                8'h00, 1'b0, 3'd1, 1'b0};
    tbl[7] = '{2'b01, 2'b00, 4, {32'h0, 32'h00000000},         8'h00, 1'b0, 3'd4, 1'b0};

    i_rst       = 1'b1;
    i_in_valid  = 1'b0;
    i_in_data   = 8'h00;
    i_in_last   = 1'b0;
    i_in_mode   = 2'b00;
    i_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    check_reset_state("reset");

    for (int t = 0; t < 8; t++) begin
      send_packet(tbl[t].mode, tbl[t].mid, tbl[t].n, tbl[t].d, 1'b0);
      check_result($sformatf("tbl%0d", t), tbl[t].ev, tbl[t].eb, tbl[t].ebeats,
                   tbl[t].eovf, 0, 1'b0);
    end

    // Backpressure in DONE with a beat offered that must be refused.
    d = {40'h0, 8'h0C, 8'h33, 8'h5A};
    send_packet(2'b10, 2'b10, 3, d, 1'b0);
    check_result("backpressure", 8'h65, 1'b0, 3'd3, 1'b0, 5, 1'b1);

    // Reset mid-packet discards the partial packet.
    i_in_valid = 1'b1; i_in_data = 8'h80; i_in_mode = 2'b01; i_in_last = 1'b0;
    @(negedge clk);
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_reset_state("rst_mid");
    d = {56'h0, 8'h01};
    send_packet(2'b01, 2'b01, 1, d, 1'b0);
    check_result("after_rst", 8'h01, 1'b1, 3'd1, 1'b0, 0, 1'b0);

    // Reset while holding a result in DONE.
    d = {56'h0, 8'hFF};
    send_packet(2'b00, 2'b00, 1, d, 1'b0);
    chk("rst_done/pre_valid", 32'(o_out_valid), 32'd1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_reset_state("rst_done");

    for (int r = 0; r < 60; r++) begin
      mode = 2'($urandom_range(0, 3));
      mid  = 2'($urandom_range(0, 3));
      n    = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      model(mode, n, d, ev, eb, ebeats, eovf);
      send_packet(mode, mid, n, d, 1'b1);
      check_result($sformatf("rand%0d", r), ev, eb, ebeats, eovf, $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
